prf_wr_port_arbiter: RTL

//  Shares the banked PRF write ports among all writeback producers. Each producer feeds a private FIFO.

---
 rtl/prf_wr_port_arbiter_if.sv | 27 ++
 rtl/prf_wr_port_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/prf_wr_port_arbiter_if.sv
// prf_wr_port_arbiter_if: producer write requests and banked PRF write-port outputs
interface prf_wr_port_arbiter_if #(
  parameter int WR_COUNT   = 8,
  parameter int BANK_COUNT = 4,
  parameter int PR_W       = 7,
  parameter int DATA_W     = 64
);
  localparam int SW = $clog2(WR_COUNT);
  localparam int BW = $clog2(BANK_COUNT);
  logic [WR_COUNT-1:0]                wr_req_valid;
  logic [WR_COUNT-1:0][PR_W-1:0]      wr_req_pr;
  logic [WR_COUNT-1:0][DATA_W-1:0]    wr_req_data;
  logic [WR_COUNT-1:0]                wr_req_ready;
  logic [BANK_COUNT-1:0]              prf_wr_valid;
  logic [BANK_COUNT-1:0][PR_W-BW-1:0] prf_wr_upper_pr;
  logic [BANK_COUNT-1:0][PR_W-1:0]    prf_wr_pr;
  logic [BANK_COUNT-1:0][DATA_W-1:0]  prf_wr_data;
  logic [BANK_COUNT-1:0][SW-1:0]      prf_wr_src;
  modport master (
    output wr_req_valid, wr_req_pr, wr_req_data,
    input  wr_req_ready, prf_wr_valid, prf_wr_upper_pr, prf_wr_pr, prf_wr_data, prf_wr_src
  );
  modport slave (
    input  wr_req_valid, wr_req_pr, wr_req_data,
    output wr_req_ready, prf_wr_valid, prf_wr_upper_pr, prf_wr_pr, prf_wr_data, prf_wr_src
  );
endinterface

// File: rtl/prf_wr_port_arbiter.sv
// prf_wr_port_arbiter: per-producer FIFOs with independent round-robin grant per PRF bank
module prf_wr_port_arbiter #(
  parameter int WR_COUNT    = 8,
  parameter int BANK_COUNT  = 4,
  parameter int BUF_ENTRIES = 2,
  parameter int PR_W        = 7,
  parameter int DATA_W      = 64
) (
  input logic CLK,
  input logic RST,
  prf_wr_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(WR_COUNT);
  localparam int BW = $clog2(BANK_COUNT);
  localparam int PW = $clog2(BUF_ENTRIES);
  localparam int CW = $clog2(BUF_ENTRIES + 1);

  logic [WR_COUNT-1:0][BUF_ENTRIES-1:0][PR_W-1:0]   buf_pr;
  logic [WR_COUNT-1:0][BUF_ENTRIES-1:0][DATA_W-1:0] buf_data;
  logic [WR_COUNT-1:0][PW-1:0]     rd_ptr, wr_ptr;
  logic [WR_COUNT-1:0][CW-1:0]     cnt, cnt_nxt;
  logic [WR_COUNT-1:0][PR_W-1:0]   head_pr;
  logic [WR_COUNT-1:0][DATA_W-1:0] head_data;
  logic [WR_COUNT-1:0]             push, pop;
  logic [BANK_COUNT-1:0][SW-1:0]   rr_ptr, gnt_idx;
  logic [BANK_COUNT-1:0]           gnt_any;
  logic [SW-1:0]                   sel;

  assign push = bus.wr_req_valid & bus.wr_req_ready;

  always_comb begin
    for (int i = 0; i < WR_COUNT; i++) begin
      head_pr[i]   = buf_pr[i][rd_ptr[i]];
      head_data[i] = buf_data[i][rd_ptr[i]];
      cnt_nxt[i]   = cnt[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // Each bank scans the ring from its own pointer; a head targets one bank, so pops never collide
  always_comb begin
    gnt_any = '0;
    gnt_idx = '0;
    pop     = '0;
    sel     = '0;
    for (int b = 0; b < BANK_COUNT; b++)
      for (int k = 0; k < WR_COUNT; k++) begin
        sel = SW'((int'(rr_ptr[b]) + k) % WR_COUNT);
        if (!gnt_any[b] && cnt[sel] != '0 && head_pr[sel][BW-1:0] == BW'(b)) begin
          gnt_any[b] = 1'b1;
          gnt_idx[b] = sel;
        end
      end
    for (int b = 0; b < BANK_COUNT; b++)
      if (gnt_any[b]) pop[gnt_idx[b]] = 1'b1;
  end

  always_ff @(posedge CLK)
    for (int i = 0; i < WR_COUNT; i++)
      if (push[i]) begin
        buf_pr[i][wr_ptr[i]]   <= bus.wr_req_pr[i];
        buf_data[i][wr_ptr[i]] <= bus.wr_req_data[i];
      end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt                 <= '0;
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      rr_ptr              <= '0;
      bus.wr_req_ready    <= '1;
      bus.prf_wr_valid    <= '0;
      bus.prf_wr_upper_pr <= '0;
      bus.prf_wr_pr       <= '0;
      bus.prf_wr_data     <= '0;
      bus.prf_wr_src      <= '0;
    end else begin
      for (int i = 0; i < WR_COUNT; i++) begin
        cnt[i]              <= cnt_nxt[i];
        bus.wr_req_ready[i] <= cnt_nxt[i] < CW'(BUF_ENTRIES);
        if (push[i]) wr_ptr[i] <= wr_ptr[i] == PW'(BUF_ENTRIES - 1) ? '0 : wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] == PW'(BUF_ENTRIES - 1) ? '0 : rd_ptr[i] + 1'b1;
      end
      for (int b = 0; b < BANK_COUNT; b++) begin
        bus.prf_wr_valid[b] <= gnt_any[b];
        if (gnt_any[b]) begin
          rr_ptr[b]              <= gnt_idx[b] == SW'(WR_COUNT - 1) ? '0 : gnt_idx[b] + 1'b1;
          bus.prf_wr_pr[b]       <= head_pr[gnt_idx[b]];
          bus.prf_wr_upper_pr[b] <= head_pr[gnt_idx[b]][PR_W-1:BW];
          bus.prf_wr_data[b]     <= head_data[gnt_idx[b]];
          bus.prf_wr_src[b]      <= gnt_idx[b];
        end
      end
    end
endmodule
